// File: rtl/conv_engine.sv
//============================================================================
// Module      : conv_engine
// Description : Pipelined 3x3 convolution over four overlapping windows per
//               beat with a runtime-loaded signed kernel, round/shift/saturate
//               to 8-bit pixels. Optional macro CONV_WARMUP_EN suppresses the
//               first WARMUP accepted beats after reset.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module conv_engine #(
    parameter int KERNEL_WIDTH = 3,
    parameter int NB_PIXEL     = 8,
    parameter int NB_CONV      = KERNEL_WIDTH*KERNEL_WIDTH*NB_PIXEL,
    parameter int NB_COEFF     = 8,
    parameter int NB_DATA      = 32,
    parameter int IMAGE_HEIGHT = 200,
    parameter int WARMUP       = IMAGE_HEIGHT + KERNEL_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [NB_CONV-1:0]         i_conv0,
    input  logic [NB_CONV-1:0]         i_conv1,
    input  logic [NB_CONV-1:0]         i_conv2,
    input  logic [NB_CONV-1:0]         i_conv3,
    input  logic                       i_kernel_we,
    input  logic signed [NB_COEFF-1:0] i_kernel_data,
    input  logic [3:0]                 i_shift,
    output logic                       o_kernel_ready,
    output logic [NB_DATA-1:0]         o_data,
    output logic                       o_valid
);

    localparam int c_LANES   = 4;
    localparam int c_NTAPS   = KERNEL_WIDTH*KERNEL_WIDTH;
    localparam int c_NB_IDX  = $clog2(c_NTAPS);
    localparam int c_NB_PROD = NB_PIXEL + 1 + NB_COEFF;
    localparam int c_NB_ROW  = c_NB_PROD + $clog2(KERNEL_WIDTH);
    localparam int c_NB_SUM  = c_NB_PROD + $clog2(c_NTAPS);
    localparam int c_NB_RND  = c_NB_SUM + 1;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_NB_IDX-1:0]         r_widx;
    logic [c_NB_IDX-1:0]         w_widx_next;
    logic                        w_last_write;
    logic signed [NB_COEFF-1:0]  r_shadow [c_NTAPS];
    logic signed [NB_COEFF-1:0]  r_active [c_NTAPS];

    logic                        w_accept;
    logic                        w_beat_valid;
    logic [NB_CONV-1:0]          r_win [c_LANES];
    logic                        r_v0;
    logic                        r_v1;
    logic                        r_v2;
    logic                        r_v3;
    logic signed [c_NB_RND-1:0]  w_bias;
    logic [NB_DATA-1:0]          w_out;

    // ---------------------------------------------------------------- kernel FSM
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_LOAD;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_widx  <= w_widx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_widx_next    = r_widx;
        w_last_write   = 1'b0;
        o_kernel_ready = (r_state == ST_RUN);
        if (i_kernel_we) begin
            if (r_widx == c_NB_IDX'(c_NTAPS-1)) begin
                w_last_write = 1'b1;
                w_widx_next  = '0;
                w_state_next = ST_RUN;
            end else begin
                w_widx_next  = r_widx + 1'b1;
                w_state_next = ST_LOAD;
            end
        end
    end

    // Active kernel only swaps on the final write so in-flight beats keep the old one.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < c_NTAPS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else if (i_kernel_we) begin
            r_shadow[r_widx] <= i_kernel_data;
            if (w_last_write) begin
                for (int k = 0; k < c_NTAPS-1; k++) begin
                    r_active[k] <= r_shadow[k];
                end
                r_active[c_NTAPS-1] <= i_kernel_data;
            end
        end
    end

    // ---------------------------------------------------------------- acceptance
    assign w_accept = i_valid & (r_state == ST_RUN);

`ifdef CONV_WARMUP_EN
    localparam int c_NB_WARM = $clog2(WARMUP + 1);
    logic [c_NB_WARM-1:0] r_warm;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_warm <= '0;
        end else if (w_accept && (r_warm != c_NB_WARM'(WARMUP))) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    assign w_beat_valid = w_accept & (r_warm == c_NB_WARM'(WARMUP));
`else
    assign w_beat_valid = w_accept;
`endif

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_win[0] <= i_conv0;
            r_win[1] <= i_conv1;
            r_win[2] <= i_conv2;
            r_win[3] <= i_conv3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            r_v0    <= w_beat_valid;
            r_v1    <= r_v0;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            o_valid <= r_v3;
            if (r_v3) begin
                o_data <= w_out;
            end
        end
    end

    assign w_bias = (i_shift == 4'd0) ? '0 : (c_NB_RND'(1) <<< (i_shift - 4'd1));

    // ---------------------------------------------------------------- per-lane datapath
    for (genvar l = 0; l < c_LANES; l++) begin : g_lane
        logic signed [c_NB_PROD-1:0] r_prod [c_NTAPS];
        logic signed [c_NB_ROW-1:0]  r_row  [KERNEL_WIDTH];
        logic signed [c_NB_SUM-1:0]  r_sum;
        logic signed [c_NB_ROW-1:0]  w_row  [KERNEL_WIDTH];
        logic signed [c_NB_SUM-1:0]  w_sum;
        logic signed [c_NB_RND-1:0]  w_rnd;
        logic [NB_PIXEL-1:0]         w_pix;

        always_ff @(posedge i_clk) begin
            for (int k = 0; k < c_NTAPS; k++) begin
                r_prod[k] <= c_NB_PROD'($signed({1'b0, r_win[l][NB_PIXEL*k +: NB_PIXEL]}))
                           * c_NB_PROD'(r_active[k]);
            end
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                r_row[r] <= w_row[r];
            end
            r_sum <= w_sum;
        end

        always_comb begin
            w_sum = '0;
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                w_row[r] = '0;
                for (int c = 0; c < KERNEL_WIDTH; c++) begin
                    w_row[r] = w_row[r] + c_NB_ROW'(r_prod[r*KERNEL_WIDTH + c]);
                end
                w_sum = w_sum + c_NB_SUM'(r_row[r]);
            end
            w_rnd = (c_NB_RND'(r_sum) + w_bias) >>> i_shift;
            if (w_rnd < 0) begin
                w_pix = '0;
            end else if (w_rnd > c_NB_RND'(255)) begin
                w_pix = '1;
            end else begin
                w_pix = w_rnd[NB_PIXEL-1:0];
            end
        end

        assign w_out[NB_PIXEL*l +: NB_PIXEL] = w_pix;
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_engine.sv
//============================================================================
// Module      : tb_conv_engine
// Description : Self-checking bench for conv_engine against a cycle-scheduled
//               behavioural model of the convolution and kernel loading.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_conv_engine;

    localparam int TB_IH = 4;
`ifdef CONV_WARMUP_EN
    localparam int WARMUP = TB_IH + 3;
`endif

    logic               clk;
    logic               rst_n;
    logic               vld;
    logic [71:0]        conv [4];
    logic               we;
    logic signed [7:0]  kd;
    logic [3:0]         shift;
    logic               o_kernel_ready;
    logic [31:0]        o_data;
    logic               o_valid;

    conv_engine #(
        .KERNEL_WIDTH (3),
        .NB_PIXEL     (8),
        .NB_CONV      (72),
        .NB_COEFF     (8),
        .NB_DATA      (32),
        .IMAGE_HEIGHT (TB_IH)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_valid        (vld),
        .i_conv0        (conv[0]),
        .i_conv1        (conv[1]),
        .i_conv2        (conv[2]),
        .i_conv3        (conv[3]),
        .i_kernel_we    (we),
        .i_kernel_data  (kd),
        .i_shift        (shift),
        .o_kernel_ready (o_kernel_ready),
        .o_data         (o_data),
        .o_valid        (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    pend_t       q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          m_shadow [9];
    int          m_active [9];
    int          m_idx;
    logic        m_ready;
    logic        m_valid;
    logic [31:0] m_data;
`ifdef CONV_WARMUP_EN
    int          m_warm;
`endif
    int          karr [9];

    function automatic logic [31:0] conv_ref(input int sh);
        logic [31:0] r;
        logic [71:0] w;
        int          s;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            w = conv[l];
            s = 0;
            for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]) * m_active[k];
            if (sh > 0) s += 1 << (sh - 1);
            s = s >>> sh;
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            r[8*l +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        pend_t p;
        @(posedge clk);
        m_valid = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_idx   = 0;
            m_data  = '0;
            for (int k = 0; k < 9; k++) begin
                m_shadow[k] = 0;
                m_active[k] = 0;
            end
`ifdef CONV_WARMUP_EN
            m_warm = 0;
`endif
        end else begin
            if (vld && m_ready) begin
                p.due  = cyc + 4;
                p.data = conv_ref(int'(shift));
`ifdef CONV_WARMUP_EN
                if (m_warm >= WARMUP) q.push_back(p);
                if (m_warm < WARMUP) m_warm++;
`else
                q.push_back(p);
`endif
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                m_valid = 1'b1;
                m_data  = q[0].data;
                void'(q.pop_front());
            end
            if (we) begin
                m_shadow[m_idx] = int'(kd);
                if (m_idx == 8) begin
                    m_active = m_shadow;
                    m_idx    = 0;
                    m_ready  = 1'b1;
                end else begin
                    m_idx++;
                    m_ready = 1'b0;
                end
            end
        end
        cyc++;
        #1;
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("ready", 32'(o_kernel_ready), 32'(m_ready));
        chk("data", o_data, m_data);
    endtask

    task automatic rand_pix();
        for (int l = 0; l < 4; l++) conv[l] = {8'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    task automatic load_kernel(input int k[9], input logic with_valid);
        for (int i = 0; i < 9; i++) begin
            we  = 1'b1;
            kd  = 8'(k[i]);
            vld = with_valid;
            rand_pix();
            tick();
        end
        we  = 1'b0;
        vld = 1'b0;
    endtask

    task automatic rand_kernel();
        for (int i = 0; i < 9; i++) karr[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic beat_expect(input string tag, input logic [31:0] exp);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        repeat (4) tick();
        chk({tag, "_v"}, 32'(o_valid), 32'd1);
        chk(tag, o_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 1'b0;
        we    = 1'b0;
        kd    = '0;
        shift = '0;
        for (int l = 0; l < 4; l++) conv[l] = '0;
        tick();
        tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_kernel_ready), 32'd0);
        chk("rst_data", o_data, 32'd0);
        rst_n = 1'b1;

        // identity kernel, with i_valid asserted during LOAD (must be dropped)
        karr = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel(karr, 1'b1);
        chk("ready_after_load", 32'(o_kernel_ready), 32'd1);

`ifdef CONV_WARMUP_EN
        for (int i = 0; i < WARMUP; i++) begin
            rand_pix();
            vld = 1'b1;
            tick();
        end
        vld = 1'b0;
        repeat (6) tick();
`endif

        rand_pix();
        for (int l = 0; l < 4; l++) conv[l][8*4 +: 8] = 8'h7F;
        shift = 4'd0;
        beat_expect("identity", 32'h7F7F7F7F);

        karr = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_kernel(karr, 1'b0);
        for (int l = 0; l < 4; l++) conv[l] = {9{8'd10}};
        shift = 4'd3;
        beat_expect("ones_round", 32'h0B0B0B0B);
        for (int l = 0; l < 4; l++) conv[l] = {9{8'd255}};
        shift = 4'd0;
        beat_expect("ones_sat_hi", 32'hFFFFFFFF);

        karr = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
        load_kernel(karr, 1'b0);
        for (int l = 0; l < 4; l++) conv[l] = {9{8'd10}};
        beat_expect("neg_sat_lo", 32'h00000000);

        // randomized kernels, pixels and shifts with bursty valid
        for (int rep = 0; rep < 4; rep++) begin
            rand_kernel();
            load_kernel(karr, 1'($urandom));
            shift = 4'($urandom_range(0, 15));
            for (int i = 0; i < 40; i++) begin
                rand_pix();
                vld = 1'($urandom);
                tick();
            end
            vld = 1'b0;
            repeat (5) tick();
        end

        // reload while results are in flight
        rand_kernel();
        load_kernel(karr, 1'b0);
        shift = 4'd5;
        for (int i = 0; i < 4; i++) begin
            rand_pix();
            vld = 1'b1;
            tick();
        end
        rand_kernel();
        for (int i = 0; i < 9; i++) begin
            we  = 1'b1;
            kd  = 8'(karr[i]);
            vld = 1'b1;
            rand_pix();
            tick();
            if (i < 8) chk("reload_not_ready", 32'(o_kernel_ready), 32'd0);
        end
        we  = 1'b0;
        vld = 1'b0;
        chk("reload_ready", 32'(o_kernel_ready), 32'd1);
        rand_pix();
        vld = 1'b1;
        tick();
        vld = 1'b0;
        repeat (5) tick();

        // reset asserted for one cycle mid-stream
        for (int i = 0; i < 3; i++) begin
            rand_pix();
            vld = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_kernel_ready), 32'd0);
        chk("midrst_data", o_data, 32'd0);
        rst_n = 1'b1;
        vld   = 1'b0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_engine.md
# conv_engine

Pipelined 3x3 convolution stage that sits directly downstream of the subframe window generator. Each accepted beat carries four overlapping 3x3 pixel windows. The block multiplies each window by a runtime-loaded signed kernel, then rounds, shifts and saturates the results. It emits four 8-bit output pixels packed in one NB_DATA word.

## Interface
- KERNEL_WIDTH, 3, window side; the kernel has KERNEL_WIDTH² coefficients.
- NB_PIXEL, 8, unsigned pixel width.
- NB_CONV, KERNEL_WIDTH*KERNEL_WIDTH*NB_PIXEL, width of one window bus.
- NB_COEFF, 8, signed coefficient width.
- NB_DATA, 32, output word width (4 × NB_PIXEL).
- IMAGE_HEIGHT, 200, padded image height of the upstream line FIFO.
- WARMUP, IMAGE_HEIGHT+KERNEL_WIDTH, number of accepted beats suppressed after reset.
- i_clk  in  1  sole clock; everything is on the rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_valid  in  1  window buses hold a new beat (same strobe that advances the window generator).
- i_conv0..i_conv3  in  NB_CONV each  windows; pixel k (k = row*3+col) sits at [NB_PIXEL*(k+1)-1 -: NB_PIXEL].
- i_kernel_we  in  1  coefficient write strobe.
- i_kernel_data  in  NB_COEFF  signed coefficient, written in index order 0..8.
- i_shift  in  4  right-shift amount (0..15), sampled at stage 4.
- o_kernel_ready  out  1  high when a complete kernel is active and beats are accepted.
- o_data  out  NB_DATA  lane n at [NB_PIXEL*(n+1)-1 -: NB_PIXEL] is the result for i_convn.
- o_valid  out  1  o_data holds a result; single-cycle pulse per result.

## Operation
- **Kernel FSM states**
  - LOAD: o_kernel_ready=0.
  - RUN: o_kernel_ready=1.
- **Reset**
  - State → LOAD, write index 0.
  - Shadow and active kernels cleared to 0.
- **Writing coefficients**
  - Each i_kernel_we writes i_kernel_data into shadow[index], then index increments.
  - On the write to index 8: active ← shadow (including the new coefficient), index → 0, state → RUN.
- **Reload**
  - i_kernel_we in RUN writes shadow[0], sets index 1 and moves to LOAD.
  - The active kernel is untouched until the 9th write, so beats already in flight finish with the old kernel.
- **Beat acceptance**
  - accept = i_valid & o_kernel_ready.
  - i_valid in LOAD is dropped: no output, warm-up counter not advanced.
- **Arithmetic, per lane**
  - Product: unsigned pixel × signed coefficient → 17-bit signed.
  - Sum: 9 products → 21-bit signed, no overflow possible.
  - Rounding: r = (sum + (i_shift ? 1<<(i_shift-1) : 0)) >>> i_shift, arithmetic shift.
  - Saturation: output = r<0 ? 0 : r>255 ? 255 : r.
- **Pipeline**
  - Free-running, never stalls.
  - S1: register 36 products.
  - S2: register 3 row sums per lane.
  - S3: register full sum.
  - S4: round/shift/saturate into o_data/o_valid.
  - A valid bit travels with each stage.
- o_data holds its last value when o_valid=0.

## Timing
- Reset values: o_data=0, o_valid=0, o_kernel_ready=0, all pipeline valid bits 0, warm-up counter 0.
- Reset asserted mid-stream: in-flight results are discarded and o_valid=0 on the cycle after the reset edge.
- Latency: an accept at edge t gives o_valid=1 at edge t+4. Back-to-back accepts give back-to-back o_valid, one result per cycle.
- o_kernel_ready timing:
  - Rises on the edge that captures the 9th coefficient; the earliest accept is on the next edge.
  - Falls on the edge capturing the first coefficient of a reload.
- i_kernel_we and i_valid on the same edge in RUN: the beat is accepted with the old kernel, then the FSM goes to LOAD.
- i_shift is sampled at S4, not at accept. It must be held stable while results are in flight.

## Configuration
- CONV_WARMUP_EN defined:
  - A saturating counter counts accepted beats.
  - The first WARMUP accepted beats after reset still flow through the pipeline, but their valid bit is forced to 0 at S1.
  - The beat numbered WARMUP+1 is the first to produce o_valid.
  - Kernel reload does not reset the counter.
- CONV_WARMUP_EN undefined: no counter is built, and every accepted beat produces o_valid.

## Test plan
- Identity kernel (coeff 4 = 1, others 0), i_shift=0, center pixel 0x7F in all lanes, accept at edge t → o_valid at t+4, o_data=0x7F7F7F7F.
- All-ones kernel, all pixels 10, i_shift=3 → (90+4)>>3 = 11, o_data=0x0B0B0B0B; same with pixels 255 and i_shift=0 → sum 2295 saturates, o_data=0xFFFFFFFF.
- All −1 kernel (0xFF), pixels 10 → sum −90 clamps, o_data=0x00000000.
- Reload while results are in flight → the 4 in-flight outputs still use the old kernel; o_kernel_ready=0 for 9 write cycles; i_valid during LOAD gives no o_valid; the first beat after ready uses the new kernel.
- CONV_WARMUP_EN with bench IMAGE_HEIGHT=4 (WARMUP=7), continuous accepts → no o_valid for beats 1–7, first o_valid 4 cycles after beat 8; without the macro, first o_valid 4 cycles after beat 1.
- i_reset=0 for one cycle with results in flight → o_valid and o_kernel_ready are 0 and o_data=0 on the next cycle; no delayed outputs appear afterwards.
